// File: rtl/chesssoc_hex_display_ctrl.sv
// Avalon-MM seven-segment display controller.
// Registered segment drive with per-digit blank/blink and a prescaled blink timer.
module chesssoc_hex_display_ctrl #(
  parameter int NUM_DIGITS     = 4,
  parameter int BLINK_DIV      = 25000000,
  parameter bit SEG_ACTIVE_LOW = 1'b1
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic [1:0]              address,
  input  logic                    chipselect,
  input  logic                    write_n,
  input  logic [31:0]             writedata,
  output logic [31:0]             readdata,
  output logic [7*NUM_DIGITS-1:0] hex_segs
);

  localparam int N  = NUM_DIGITS;
  localparam int CW = (BLINK_DIV > 2) ? $clog2(BLINK_DIV) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(BLINK_DIV - 1);
  localparam logic [6:0] DARK = SEG_ACTIVE_LOW ? 7'h7F : 7'h00;

  logic [4*N-1:0] value_q, value_d;
  logic [N-1:0]   blank_q, blank_d;
  logic [N-1:0]   blink_q, blink_d;
  logic           dec_en_q, dec_en_d;
  logic           blink_en_q, blink_en_d;
  logic           phase_q, phase_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [7*N-1:0] segs_q, segs_d;

  logic wr_en;
  logic unused_wd;

  assign wr_en     = chipselect & ~write_n;
  assign unused_wd = ^writedata;
  assign hex_segs  = segs_q;

  function automatic logic [6:0] seg_dec(input logic [3:0] n);
    logic [6:0] s;
    unique case (n)
      4'h0: s = 7'h3F;
      4'h1: s = 7'h06;
      4'h2: s = 7'h5B;
      4'h3: s = 7'h4F;
      4'h4: s = 7'h66;
      4'h5: s = 7'h6D;
      4'h6: s = 7'h7D;
      4'h7: s = 7'h07;
      4'h8: s = 7'h7F;
      4'h9: s = 7'h6F;
      4'hA: s = 7'h77;
      4'hB: s = 7'h7C;
      4'hC: s = 7'h39;
      4'hD: s = 7'h5E;
      4'hE: s = 7'h79;
      default: s = 7'h71;
    endcase
    return s;
  endfunction

  always_comb begin
    value_d    = value_q;
    blank_d    = blank_q;
    blink_d    = blink_q;
    dec_en_d   = dec_en_q;
    blink_en_d = blink_en_q;
    cnt_d      = cnt_q;
    phase_d    = phase_q;

    if (blink_en_q) begin
      if (cnt_q == CNT_MAX) begin
        cnt_d   = '0;
        phase_d = ~phase_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end else begin
      cnt_d   = '0;
      phase_d = 1'b0;
    end

    if (wr_en) begin
      unique case (address)
        2'd0: value_d = writedata[4*N-1:0];
        2'd1: blank_d = writedata[N-1:0];
        2'd2: blink_d = writedata[N-1:0];
        default: begin
          dec_en_d   = writedata[0];
          blink_en_d = writedata[1];
          // Disabling blink overrides a coincident timer wrap.
          if (!writedata[1]) begin
            cnt_d   = '0;
            phase_d = 1'b0;
          end
        end
      endcase
    end
  end

  always_comb begin
    logic       dark;
    logic [6:0] pat;
    segs_d = '0;
    dark   = 1'b0;
    pat    = '0;
    for (int i = 0; i < N; i++) begin
      dark = ~dec_en_q | blank_q[i] |
             (blink_en_q & blink_q[i] & phase_q);
      pat  = dark ? 7'h00 : seg_dec(value_q[4*i +: 4]);
      segs_d[7*i +: 7] = SEG_ACTIVE_LOW ? ~pat : pat;
    end
  end

  always_comb begin
    readdata = '0;
    if (chipselect) begin
      unique case (address)
        2'd0: readdata[4*N-1:0] = value_q;
        2'd1: readdata[N-1:0]   = blank_q;
        2'd2: readdata[N-1:0]   = blink_q;
        default: readdata[2:0]  = {phase_q, blink_en_q, dec_en_q};
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      value_q    <= '0;
      blank_q    <= '0;
      blink_q    <= '0;
      dec_en_q   <= 1'b1;
      blink_en_q <= 1'b0;
      phase_q    <= 1'b0;
      cnt_q      <= '0;
      segs_q     <= {N{DARK}};
    end else begin
      value_q    <= value_d;
      blank_q    <= blank_d;
      blink_q    <= blink_d;
      dec_en_q   <= dec_en_d;
      blink_en_q <= blink_en_d;
      phase_q    <= phase_d;
      cnt_q      <= cnt_d;
      segs_q     <= segs_d;
    end
  end

endmodule

// File: tb/tb_chesssoc_hex_display_ctrl.sv
// Directed bench for chesssoc_hex_display_ctrl.
// N=4, BLINK_DIV=4, active-low segments.
module tb_chesssoc_hex_display_ctrl;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [1:0]  address = '0;
  logic        chipselect = 1'b0;
  logic        write_n = 1'b1;
  logic [31:0] writedata = '0;
  logic [31:0] readdata;
  logic [27:0] hex_segs;

  int checks = 0;
  int failures = 0;

  localparam logic [27:0] ALL_DARK = {4{7'h7F}};
  localparam logic [27:0] ALL_ZERO = {4{7'h40}};
  localparam logic [27:0] V1234    = {7'h79, 7'h24, 7'h30, 7'h19};

  chesssoc_hex_display_ctrl #(
    .NUM_DIGITS(4),
    .BLINK_DIV(4),
    .SEG_ACTIVE_LOW(1'b1)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .address(address),
    .chipselect(chipselect),
    .write_n(write_n),
    .writedata(writedata),
    .readdata(readdata),
    .hex_segs(hex_segs)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    @(negedge clk);
    chipselect = 1'b1;
    write_n    = 1'b0;
    address    = a;
    writedata  = d;
    @(posedge clk);
    #1;
    chipselect = 1'b0;
    write_n    = 1'b1;
  endtask

  task automatic rd_chk(input string tag, input logic [1:0] a,
                        input logic [31:0] exp);
    chipselect = 1'b1;
    write_n    = 1'b1;
    address    = a;
    #1;
    chk(tag, readdata, exp);
    chipselect = 1'b0;
  endtask

  task automatic edge1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic ph;
    #23;
    chk("reset_segs", {4'h0, hex_segs}, {4'h0, ALL_DARK});
    @(negedge clk);
    reset_n = 1'b1;
    edge1();
    chk("first_edge_zero", {4'h0, hex_segs}, {4'h0, ALL_ZERO});
    rd_chk("ctrl_reset", 2'd3, 32'h1);
    rd_chk("value_reset", 2'd0, 32'h0);
    rd_chk("blink_reset", 2'd2, 32'h0);

    wr(2'd0, 32'hABCD1234);
    chk("value_not_yet", {4'h0, hex_segs}, {4'h0, ALL_ZERO});
    rd_chk("value_rd", 2'd0, 32'h1234);
    edge1();
    chk("value_segs", {4'h0, hex_segs}, {4'h0, V1234});
    address = 2'd0;
    #1;
    chk("rd_no_cs", readdata, 32'h0);

    wr(2'd1, 32'hFFFFFFF5);
    edge1();
    chk("blank_segs", {4'h0, hex_segs},
        {4'h0, 7'h79, 7'h7F, 7'h30, 7'h7F});
    rd_chk("blank_rd", 2'd1, 32'h5);
    wr(2'd1, 32'h0);

    wr(2'd2, 32'h1);
    rd_chk("blink_rd", 2'd2, 32'h1);
    wr(2'd3, 32'h3);
    for (int j = 1; j <= 11; j++) begin
      edge1();
      ph = ((j - 1) / 4) % 2 == 1;
      chk($sformatf("blink_segs_%0d", j), {4'h0, hex_segs},
          {4'h0, V1234[27:7], ph ? 7'h7F : 7'h19});
      ph = (j / 4) % 2 == 1;
      rd_chk($sformatf("blink_ctrl_%0d", j), 2'd3, {29'h0, ph, 2'b11});
    end

    wr(2'd3, 32'h1);
    rd_chk("wrap_ctrl", 2'd3, 32'h1);
    for (int j = 0; j < 6; j++) begin
      edge1();
      chk($sformatf("hold_segs_%0d", j), {4'h0, hex_segs},
          {4'h0, V1234});
      rd_chk($sformatf("hold_ctrl_%0d", j), 2'd3, 32'h1);
    end

    wr(2'd3, 32'h0);
    edge1();
    chk("dec_off_segs", {4'h0, hex_segs}, {4'h0, ALL_DARK});

    wr(2'd3, 32'h3);
    for (int j = 1; j <= 5; j++) begin
      edge1();
      ph = (j / 4) % 2 == 1;
      rd_chk($sformatf("reen_ctrl_%0d", j), 2'd3, {29'h0, ph, 2'b11});
    end
    chk("reen_dark", {4'h0, hex_segs}, {4'h0, V1234[27:7], 7'h7F});

    #1;
    reset_n = 1'b0;
    #1;
    chk("async_rst_segs", {4'h0, hex_segs}, {4'h0, ALL_DARK});
    rd_chk("rst_value", 2'd0, 32'h0);
    rd_chk("rst_blank", 2'd1, 32'h0);
    rd_chk("rst_blink", 2'd2, 32'h0);
    rd_chk("rst_ctrl", 2'd3, 32'h1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
